// File: rtl/meter_pkg.sv
// Shared definitions for the microphone level meter: level/LED widths,
// the peak-marker FSM state encoding and the bar-graph thermometer encoder.
package meter_pkg;

    localparam int LEVEL_W = 4;
    localparam int LED_W   = 16;   // one LED per representable level

    // Peak-marker FSM states
    typedef enum logic [1:0] {
        PK_IDLE = 2'd0,
        PK_HOLD = 2'd1,
        PK_FALL = 2'd2
    } peak_state_e;

    // Thermometer code: bit i is lit when i is below the level, so level 0
    // lights nothing and level 15 lights bits 14..0.
    function automatic logic [LED_W-1:0] thermo_encode(input logic [LEVEL_W-1:0] lvl);
        logic [LED_W-1:0] t;
        t = '0;
        for (int i = 0; i < LED_W; i++) begin
            t[i] = (i < int'(lvl));
        end
        return t;
    endfunction

endpackage

// File: rtl/meter_tick_gen.sv
// Free-running decay timebase: counts 0..DECAY_TICKS-1 and raises tick for
// the single cycle in which the count sits at its last value.
module meter_tick_gen #(
    parameter int DECAY_TICKS = 2000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                CNT_W    = $clog2(DECAY_TICKS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECAY_TICKS - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Wrapping counter; never restarted by level strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/level_meter_hold.sv
// LED bar-graph meter with instant attack, linear timed decay and an
// optional peak-hold marker.
// Build option: define METER_PEAK_HOLD_EN to include the peak FSM, hold
// counter and LED marker; without it the peak outputs simply mirror the bar.
module level_meter_hold
    import meter_pkg::*;
#(
    parameter int DECAY_TICKS = 2000,
    parameter int HOLD_TICKS  = 20000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] level_in,
    input  logic               level_valid,
    output logic [LED_W-1:0]   led,
    output logic [LEVEL_W-1:0] disp_level,
    output logic [LEVEL_W-1:0] peak_level,
    output logic               peak_active
);

    logic               tick;
    logic [LEVEL_W-1:0] disp_reg;
    logic [LEVEL_W-1:0] disp_next;
    logic [LED_W-1:0]   marker;
    logic [LED_W-1:0]   led_reg;

    meter_tick_gen #(
        .DECAY_TICKS(DECAY_TICKS)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Bar height: a louder-or-equal strobe jumps straight up, otherwise the
    // bar only ever comes down one step per decay tick, stopping at zero.
    always_comb begin
        disp_next = disp_reg;
        if (level_valid && (level_in >= disp_reg)) begin
            disp_next = level_in;
        end else if (tick && (disp_reg != '0)) begin
            disp_next = disp_reg - 1'b1;
        end
    end

    // Bar register
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_reg <= '0;
        end else begin
            disp_reg <= disp_next;
        end
    end

`ifdef METER_PEAK_HOLD_EN
    localparam int                 HOLD_W      = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(HOLD_TICKS - 1);

    localparam logic [1:0] ST_IDLE = PK_IDLE;
    localparam logic [1:0] ST_HOLD = PK_HOLD;
    localparam logic [1:0] ST_FALL = PK_FALL;

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [HOLD_W-1:0]  hold_reg;
    logic [HOLD_W-1:0]  hold_next;
    logic [LEVEL_W-1:0] peak_reg;
    logic [LEVEL_W-1:0] peak_next;
    logic               peak_active_reg;

    // Peak FSM: a new maximum always (re)starts the hold, even over a decay
    // tick; after the hold expires the marker falls one step per tick until
    // it meets the bar, then it rides on the bar again.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        peak_next  = peak_reg;
        if (level_valid && (level_in > peak_reg)) begin
            peak_next  = level_in;
            hold_next  = HOLD_RELOAD;
            state_next = ST_HOLD;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (level_valid && (level_in == peak_reg) && (level_in != '0)) begin
                        hold_next = HOLD_RELOAD;
                    end else if (hold_reg == '0) begin
                        state_next = ST_FALL;
                    end else begin
                        hold_next = hold_reg - 1'b1;
                    end
                end
                ST_FALL: begin
                    if (tick) begin
                        // The zero guard keeps the decrement from wrapping
                        if ((peak_reg == '0) || ((peak_reg - 1'b1) <= disp_next)) begin
                            peak_next  = disp_next;
                            state_next = ST_IDLE;
                        end else begin
                            peak_next = peak_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    peak_next  = disp_next;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Peak FSM registers; peak_active is registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            hold_reg        <= '0;
            peak_reg        <= '0;
            peak_active_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_reg        <= hold_next;
            peak_reg        <= peak_next;
            peak_active_reg <= (state_next != ST_IDLE);
        end
    end

    // One-hot marker at the peak position, only while the marker is live
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_marker
        assign marker[gi] = peak_active_reg && (peak_reg == LEVEL_W'(gi));
    end

    assign peak_level  = peak_reg;
    assign peak_active = peak_active_reg;
`else
    // Bar-only build: the peak outputs follow the bar and no marker is drawn
    assign marker      = '0;
    assign peak_level  = disp_reg;
    assign peak_active = 1'b0;
`endif

    // LED image, one cycle behind the bar/peak registers
    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg <= '0;
        end else begin
            led_reg <= thermo_encode(disp_reg) | marker;
        end
    end

    assign led        = led_reg;
    assign disp_level = disp_reg;

endmodule

// File: tb/tb_level_meter_hold.sv
// Randomised scoreboard bench for level_meter_hold (DECAY_TICKS=4,
// HOLD_TICKS=10). Expected outputs come from a time-based reference model
// and are compared every cycle by an independent monitor.
module tb_level_meter_hold;

    localparam int DT = 4;
    localparam int HT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  level_in = '0;
    logic        level_valid = 1'b0;
    logic [15:0] led;
    logic [3:0]  disp_level;
    logic [3:0]  peak_level;
    logic        peak_active;

    always #5 clk = ~clk;

    level_meter_hold #(
        .DECAY_TICKS(DT),
        .HOLD_TICKS (HT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .level_in   (level_in),
        .level_valid(level_valid),
        .led        (led),
        .disp_level (disp_level),
        .peak_level (peak_level),
        .peak_active(peak_active)
    );

    typedef struct {
        int led;
        int disp;
        int peak;
        int act;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_push  = 0;

    // Reference model: time measured in cycles since the last reset.
    // m_mode: 0 = marker on bar, 1 = frozen, 2 = falling.
    int m_time = 0;
    int m_disp = 0;
    int m_peak = 0;
    int m_mode = 0;
    int m_hold_end = 0;
    int m_led = 0;

    task automatic model_step(input bit r, input bit v, input int lvl);
        bit tick;
        int nd;
        int nl;
        if (r) begin
            m_time = 0; m_disp = 0; m_peak = 0; m_mode = 0; m_led = 0;
            return;
        end
        tick = ((m_time % DT) == DT - 1);
        // LED image reflects the bar/peak shown during this cycle
        nl = (1 << m_disp) - 1;
`ifdef METER_PEAK_HOLD_EN
        if (m_mode != 0) nl = nl | (1 << m_peak);
`endif
        if (v && lvl >= m_disp)        nd = lvl;
        else if (tick && m_disp > 0)   nd = m_disp - 1;
        else                           nd = m_disp;
`ifdef METER_PEAK_HOLD_EN
        if (v && lvl > m_peak) begin
            m_peak = lvl; m_mode = 1; m_hold_end = m_time + HT;
        end else if (m_mode == 1) begin
            if (v && lvl == m_peak && lvl != 0) m_hold_end = m_time + HT;
            else if (m_time >= m_hold_end)      m_mode = 2;
        end else if (m_mode == 2) begin
            if (tick) begin
                if (m_peak - 1 <= nd) begin m_peak = nd; m_mode = 0; end
                else m_peak = m_peak - 1;
            end
        end else begin
            m_peak = nd;
        end
`else
        m_peak = nd;
        m_mode = 0;
`endif
        m_disp = nd;
        m_led  = nl;
        m_time++;
    endtask

    // Drive one cycle of stimulus and queue the response it must produce
    task automatic drive(input bit r, input bit v, input int lvl);
        exp_t e;
        @(negedge clk);
        rst         = r;
        level_valid = v;
        level_in    = 4'(lvl);
        if (v) $display("[TB] cycle %0d: strobe level=%0d%s", n_push, lvl, r ? " (with rst)" : "");
        model_step(r, v, lvl);
        e.led  = m_led;
        e.disp = m_disp;
        e.peak = m_peak;
        e.act  = (m_mode != 0) ? 1 : 0;
        e.idx  = n_push;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0);
    endtask

    // Monitor: every cycle the DUT presents a new output set
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (int'(led) != e.led || int'(disp_level) != e.disp ||
                    int'(peak_level) != e.peak || int'(peak_active) != e.act) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got led=%h disp=%0d peak=%0d act=%0d, want led=%h disp=%0d peak=%0d act=%0d",
                             e.idx, led, disp_level, peak_level, peak_active,
                             16'(e.led), e.disp, e.peak, e.act);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        // Reset
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        // Single strobe then full decay, hold and fall back to the bar
        drive(1'b0, 1'b1, 9);
        idle(70);
        // Falling marker overtaken by a new peak; low strobe ignored by bar
        drive(1'b0, 1'b1, 10);
        idle(HT + 3 * DT + 2);
        drive(1'b0, 1'b1, 12);
        idle(3);
        drive(1'b0, 1'b1, 5);
        idle(5);
        // Full scale, refreshed often enough that the hold never expires
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 15);
            idle(5);
        end
        idle(30);
        // Reset while the marker is falling, with a coincident strobe
        drive(1'b0, 1'b1, 9);
        idle(HT + 2 * DT + 3);
        drive(1'b1, 1'b1, 13);
        idle(10);
        // Randomised bursts separated by quiet stretches
        for (int seg = 0; seg < 60; seg++) begin
            int burst;
            idle($urandom_range(0, 50));
            burst = $urandom_range(1, 20);
            for (int k = 0; k < burst; k++) begin
                if ($urandom_range(0, 199) == 0)
                    drive(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
                else if ($urandom_range(0, 3) == 0)
                    drive(1'b0, 1'b1, $urandom_range(0, 15));
                else
                    drive(1'b0, 1'b0, $urandom_range(0, 15));
            end
        end
        idle(5);
        // Let the monitor drain the scoreboard, bounded
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
